// File: rtl/apb_alu_regif_pkg.sv
// Shared definitions for the APB ALU front-end: register map, command set,
// engine states, STATUS bit positions and per-command latency.
package alu_regif_pkg;

    localparam logic [31:0] ADDR_OPA    = 32'h00;
    localparam logic [31:0] ADDR_OPB    = 32'h04;
    localparam logic [31:0] ADDR_CTRL   = 32'h08;
    localparam logic [31:0] ADDR_RESULT = 32'h0C;
    localparam logic [31:0] ADDR_STATUS = 32'h10;

    localparam int CTRL_START_BIT  = 8;
    localparam int CTRL_IRQ_EN_BIT = 9;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_CMD_ERR = 2;
    localparam int ST_CARRY   = 3;
    localparam int ST_ZERO    = 4;
    localparam int ST_EQUAL   = 5;
    localparam int ST_GREATER = 6;
    localparam int ST_LESS    = 7;

    typedef enum logic [3:0] {
        CMD_ADD   = 4'd0,
        CMD_SUB   = 4'd1,
        CMD_AND   = 4'd2,
        CMD_OR    = 4'd3,
        CMD_XOR   = 4'd4,
        CMD_NOT_A = 4'd5,
        CMD_INC_A = 4'd6,
        CMD_DEC_A = 4'd7,
        CMD_MUL   = 4'd8,
        CMD_CMP   = 4'd9
    } alu_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } eng_state_e;

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return cmd <= 4'd9;
    endfunction

    function automatic logic [1:0] cmd_latency(input alu_cmd_e cmd);
        return (cmd == CMD_MUL) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/apb_alu_regif_if.sv
// APB slave bus plus the level interrupt of the ALU front-end.
interface apb_alu_regif_if #(
    parameter int AW = 5
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic          irq;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr, irq
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr, irq
    );
endinterface

// File: rtl/apb_alu_regif_engine.sv
// ALU compute engine: captures operands on start, counts down the command
// latency, then publishes RESULT and flags with a sticky done.
//
//   state | meaning
//   IDLE  | waiting for start; done/flags hold last outcome
//   EXEC  | operation in flight, r_cnt counts down to 0
module alu_regif_engine
    import alu_regif_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [3:0]    i_cmd,
    input  logic [DW-1:0] i_opa,
    input  logic [DW-1:0] i_opb,
    input  logic          i_clr_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_cmd_err,
    output logic          o_carry,
    output logic          o_zero,
    output logic          o_equal,
    output logic          o_greater,
    output logic          o_less,
    output logic [2*DW-1:0] o_result
);
    localparam int RW = 2 * DW;

    eng_state_e    r_state;
    logic [1:0]    r_cnt;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    alu_cmd_e      r_op;
    logic          r_done;
    logic          r_cmd_err;
    logic          r_carry;
    logic          r_zero;
    logic          r_equal;
    logic          r_greater;
    logic          r_less;
    logic [RW-1:0] r_result;

    logic [DW:0]   w_ext;
    logic [RW-1:0] w_res;
    logic          w_carry;
    logic          w_eq;
    logic          w_gt;
    logic          w_lt;

    // w_ext carries the DW-bit result plus carry/borrow; logic ops leave bit DW at 0.
    always_comb begin
        w_ext = '0;
        w_eq  = 1'b0;
        w_gt  = 1'b0;
        w_lt  = 1'b0;
        case (r_op)
            CMD_ADD:   w_ext = {1'b0, r_a} + {1'b0, r_b};
            CMD_SUB:   w_ext = {1'b0, r_a} - {1'b0, r_b};
            CMD_AND:   w_ext = {1'b0, r_a & r_b};
            CMD_OR:    w_ext = {1'b0, r_a | r_b};
            CMD_XOR:   w_ext = {1'b0, r_a ^ r_b};
            CMD_NOT_A: w_ext = {1'b0, ~r_a};
            CMD_INC_A: w_ext = {1'b0, r_a} + (DW+1)'(1);
            CMD_DEC_A: w_ext = {1'b0, r_a} - (DW+1)'(1);
            CMD_CMP: begin
                w_eq = (r_a == r_b);
                w_gt = (r_a > r_b);
                w_lt = (r_a < r_b);
            end
            default: ;
        endcase
        w_carry = w_ext[DW];
        if (r_op == CMD_MUL) begin
            w_res = RW'(r_a) * RW'(r_b);
        end else begin
            w_res = RW'(w_ext);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= CMD_ADD;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
            r_less    <= 1'b0;
            r_result  <= '0;
        end else begin
            // A completion on the same edge overrides this clear below.
            if (i_clr_done) begin
                r_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_done    <= 1'b0;
                        r_cmd_err <= 1'b0;
                        r_carry   <= 1'b0;
                        r_zero    <= 1'b0;
                        r_equal   <= 1'b0;
                        r_greater <= 1'b0;
                        r_less    <= 1'b0;
                        if (cmd_is_valid(i_cmd)) begin
                            r_a     <= i_opa;
                            r_b     <= i_opb;
                            r_op    <= alu_cmd_e'(i_cmd);
                            r_cnt   <= cmd_latency(alu_cmd_e'(i_cmd)) - 2'd1;
                            r_state <= EXEC;
                        end else begin
                            r_done    <= 1'b1;
                            r_cmd_err <= 1'b1;
                            r_result  <= '0;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 2'd0) begin
                        r_result  <= w_res;
                        r_carry   <= w_carry;
                        r_zero    <= (w_res == '0);
                        r_equal   <= w_eq;
                        r_greater <= w_gt;
                        r_less    <= w_lt;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state == EXEC);
    assign o_done    = r_done;
    assign o_cmd_err = r_cmd_err;
    assign o_carry   = r_carry;
    assign o_zero    = r_zero;
    assign o_equal   = r_equal;
    assign o_greater = r_greater;
    assign o_less    = r_less;
    assign o_result  = r_result;

endmodule

// File: rtl/apb_alu_regif.sv
// APB register front-end for the ALU: address decode, operand/control
// registers, error responses and RESULT read stretching while busy.
module apb_alu_regif
    import alu_regif_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    apb_alu_regif_if.slave s_apb
);
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [3:0]    r_cmd;
    logic          r_irq_en;

    logic [31:0]     w_addr;
    logic            w_access;
    logic            w_sel_opa;
    logic            w_sel_opb;
    logic            w_sel_ctrl;
    logic            w_sel_res;
    logic            w_sel_sts;
    logic            w_mapped;
    logic            w_ready;
    logic            w_xfer;
    logic            w_err;
    logic            w_wr_ok;
    logic            w_start;
    logic            w_clr_done;
    logic [31:0]     w_rdata;
    logic [31:0]     w_status;
    logic            w_unused_pwdata;

    logic            w_busy;
    logic            w_done;
    logic            w_cmd_err;
    logic            w_carry;
    logic            w_zero;
    logic            w_equal;
    logic            w_greater;
    logic            w_less;
    logic [2*DW-1:0] w_result;

    assign w_addr     = {{(32-AW){1'b0}}, s_apb.paddr[AW-1:0]};
    assign w_access   = s_apb.psel & s_apb.penable;
    assign w_sel_opa  = (w_addr == ADDR_OPA);
    assign w_sel_opb  = (w_addr == ADDR_OPB);
    assign w_sel_ctrl = (w_addr == ADDR_CTRL);
    assign w_sel_res  = (w_addr == ADDR_RESULT);
    assign w_sel_sts  = (w_addr == ADDR_STATUS);
    assign w_mapped   = w_sel_opa | w_sel_opb | w_sel_ctrl | w_sel_res | w_sel_sts;

    // Only a RESULT read during an operation waits; it completes with the new value.
    assign w_ready = ~(w_access & ~s_apb.pwrite & w_sel_res & w_busy);
    assign w_xfer  = w_access & w_ready;

    always_comb begin
        if (s_apb.pwrite) begin
            w_err = ~w_mapped | w_sel_res | w_sel_sts
                  | (w_sel_ctrl & s_apb.pwdata[CTRL_START_BIT] & w_busy);
        end else begin
            w_err = ~w_mapped;
        end
    end

    assign w_wr_ok    = w_xfer & s_apb.pwrite & ~w_err;
    assign w_start    = w_wr_ok & w_sel_ctrl & s_apb.pwdata[CTRL_START_BIT];
    assign w_clr_done = w_xfer & ~s_apb.pwrite & w_sel_sts;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_irq_en <= 1'b0;
        end else if (w_wr_ok) begin
            if (w_sel_opa) begin
                r_opa <= s_apb.pwdata[DW-1:0];
            end
            if (w_sel_opb) begin
                r_opb <= s_apb.pwdata[DW-1:0];
            end
            if (w_sel_ctrl) begin
                r_cmd    <= s_apb.pwdata[3:0];
                r_irq_en <= s_apb.pwdata[CTRL_IRQ_EN_BIT];
            end
        end
    end

    alu_regif_engine #(.DW(DW)) u_engine (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_start),
        .i_cmd      (s_apb.pwdata[3:0]),
        .i_opa      (r_opa),
        .i_opb      (r_opb),
        .i_clr_done (w_clr_done),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_cmd_err  (w_cmd_err),
        .o_carry    (w_carry),
        .o_zero     (w_zero),
        .o_equal    (w_equal),
        .o_greater  (w_greater),
        .o_less     (w_less),
        .o_result   (w_result)
    );

    always_comb begin
        w_status             = '0;
        w_status[ST_BUSY]    = w_busy;
        w_status[ST_DONE]    = w_done;
        w_status[ST_CMD_ERR] = w_cmd_err;
        w_status[ST_CARRY]   = w_carry;
        w_status[ST_ZERO]    = w_zero;
        w_status[ST_EQUAL]   = w_equal;
        w_status[ST_GREATER] = w_greater;
        w_status[ST_LESS]    = w_less;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_opa) begin
            w_rdata = 32'(r_opa);
        end else if (w_sel_opb) begin
            w_rdata = 32'(r_opb);
        end else if (w_sel_ctrl) begin
            w_rdata[3:0]            = r_cmd;
            w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
        end else if (w_sel_res) begin
            w_rdata = 32'(w_result);
        end else if (w_sel_sts) begin
            w_rdata = w_status;
        end
    end

    assign s_apb.prdata  = (w_xfer & ~s_apb.pwrite) ? w_rdata : 32'h0;
    assign s_apb.pready  = w_ready;
    assign s_apb.pslverr = w_xfer & w_err;
    assign s_apb.irq     = w_done & r_irq_en;

    assign w_unused_pwdata = ^{s_apb.pwdata[31:10], s_apb.pwdata[7:4]};

endmodule

// File: tb/tb_apb_alu_regif.sv
// Scoreboard bench for apb_alu_regif: driver pushes expected APB responses from
// an edge-indexed reference model; a negedge monitor pops and compares them.
module tb_apb_alu_regif;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int MASK = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    apb_alu_regif_if #(.AW(AW)) bus ();

    apb_alu_regif #(.DW(DW), .AW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_apb (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Reference model; "after edge x" state is derived from the last start edge.
    logic [7:0] m_opa, m_opb;
    logic [3:0] m_cmd;
    bit         m_irq_en;
    bit         op_valid, op_inv, op_cleared;
    bit         op_c, op_z, op_eq, op_gt, op_lt;
    int         op_t0, op_done_pt, op_res, prev_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_opa = 0; m_opb = 0; m_cmd = 0; m_irq_en = 0;
        op_valid = 0; op_inv = 0; op_cleared = 0;
        op_c = 0; op_z = 0; op_eq = 0; op_gt = 0; op_lt = 0;
        op_t0 = 0; op_done_pt = 0; op_res = 0; prev_res = 0;
    endtask

    function automatic bit busy_at(input int x);
        return op_valid && !op_inv && x >= op_t0 && x < op_done_pt;
    endfunction

    function automatic bit done_at(input int x);
        return op_valid && x >= op_done_pt && !op_cleared;
    endfunction

    function automatic int result_at(input int x);
        return (op_valid && x >= op_done_pt) ? op_res : prev_res;
    endfunction

    function automatic logic [31:0] status_at(input int x);
        logic [31:0] s = '0;
        if (op_valid) begin
            s[0] = busy_at(x);
            if (x >= op_done_pt) begin
                s[1] = !op_cleared; s[2] = op_inv; s[3] = op_c; s[4] = op_z;
                s[5] = op_eq;       s[6] = op_gt;  s[7] = op_lt;
            end
        end
        return s;
    endfunction

    task automatic model_start(input int cmd, input int t0);
        int a = int'(m_opa);
        int b = int'(m_opb);
        int lat = 1;
        prev_res = result_at(t0 - 1);
        op_inv = 0; op_eq = 0; op_gt = 0; op_lt = 0;
        case (cmd)
            0: op_res = a + b;
            1: op_res = ((a - b) & MASK) | ((a < b) ? (MASK + 1) : 0);
            2: op_res = a & b;
            3: op_res = a | b;
            4: op_res = a ^ b;
            5: op_res = (~a) & MASK;
            6: op_res = a + 1;
            7: op_res = ((a - 1) & MASK) | ((a == 0) ? (MASK + 1) : 0);
            8: begin op_res = a * b; lat = 3; end
            9: begin op_res = 0; op_eq = (a == b); op_gt = (a > b); op_lt = (a < b); end
            default: begin op_res = 0; op_inv = 1; end
        endcase
        op_c = (cmd == 0 || cmd == 1 || cmd == 6 || cmd == 7) && op_res > MASK;
        op_z = !op_inv && op_res == 0;
        op_valid = 1; op_cleared = 0; op_t0 = t0;
        op_done_pt = op_inv ? t0 : t0 + lat;
    endtask

    // Called #1 after a rising edge; performs one APB transfer and updates the model.
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                            input string name);
        int   e_pred = cyc + 2;
        int   exp_waits = 0;
        int   waits = 0;
        bit   got = 0;
        bit   err;
        bit   mapped;
        exp_t ex;
        mapped = (addr == 8'h00 || addr == 8'h04 || addr == 8'h08 || addr == 8'h0C || addr == 8'h10);
        ex.name  = name;
        ex.rdata = 32'h0;
        if (wr) begin
            err = !mapped || addr == 8'h0C || addr == 8'h10 ||
                  (addr == 8'h08 && data[8] && busy_at(e_pred - 1));
        end else begin
            err = !mapped;
            case (addr)
                8'h00: ex.rdata = 32'(m_opa);
                8'h04: ex.rdata = 32'(m_opb);
                8'h08: ex.rdata = 32'(m_cmd) | (m_irq_en ? 32'h200 : 32'h0);
                8'h0C: begin
                    if (busy_at(e_pred - 1)) begin
                        ex.rdata  = 32'(op_res);
                        exp_waits = op_done_pt - (e_pred - 1);
                    end else begin
                        ex.rdata = 32'(result_at(e_pred - 1));
                    end
                end
                8'h10: ex.rdata = status_at(e_pred - 1);
                default: ex.rdata = 32'h0;
            endcase
        end
        ex.err = err;
        sb.push_back(ex);

        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr[AW-1:0]; bus.pwdata = data;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (bus.pready) got = 1;
            else waits++;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s: PREADY still low after 16 cycles", name);
        end
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        check({name, "/waits"}, 32'(waits), 32'(exp_waits));

        if (!err) begin
            if (wr) begin
                case (addr)
                    8'h00: m_opa = data[7:0];
                    8'h04: m_opb = data[7:0];
                    8'h08: begin
                        m_cmd = data[3:0];
                        m_irq_en = data[9];
                        if (data[8]) model_start(int'(data[3:0]), cyc);
                    end
                    default: ;
                endcase
            end else if (addr == 8'h10 && op_valid && cyc > op_done_pt) begin
                op_cleared = 1;
            end
        end
        check({name, "/irq"}, 32'(bus.irq), 32'(done_at(cyc) && m_irq_en));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "/prdata"}, bus.prdata, 32'h0);
        check({name, "/pready"}, 32'(bus.pready), 32'h1);
        check({name, "/pslverr"}, 32'(bus.pslverr), 32'h0);
        check({name, "/irq"}, 32'(bus.irq), 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.psel && bus.penable && bus.pready) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard: transfer completed with nothing expected");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "/prdata"}, bus.prdata, e.rdata);
                check({e.name, "/pslverr"}, 32'(bus.pslverr), 32'(e.err));
            end
        end
    end

    logic [7:0] addrs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h02};

    initial begin
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);
        apb_xfer(0, 8'h10, 0, "rst_status");
        apb_xfer(0, 8'h0C, 0, "rst_result");
        apb_xfer(0, 8'h08, 0, "rst_ctrl");

        // ADD with carry out
        apb_xfer(1, 8'h00, 32'hF0, "add_opa");
        apb_xfer(1, 8'h04, 32'h20, "add_opb");
        apb_xfer(1, 8'h08, 32'h100, "add_start");
        apb_xfer(0, 8'h10, 0, "add_status");
        apb_xfer(0, 8'h0C, 0, "add_result");
        check("add_model_result", 32'(result_at(cyc)), 32'h110);

        // MUL with immediate stretched RESULT read
        apb_xfer(1, 8'h00, 32'h0F, "mul_opa");
        apb_xfer(1, 8'h04, 32'h0F, "mul_opb");
        apb_xfer(1, 8'h08, 32'h108, "mul_start");
        apb_xfer(0, 8'h0C, 0, "mul_result_stall");
        apb_xfer(0, 8'h10, 0, "mul_status");

        // Start while busy is rejected
        apb_xfer(1, 8'h08, 32'h108, "mul2_start");
        apb_xfer(1, 8'h08, 32'h101, "busy_start");
        apb_xfer(0, 8'h0C, 0, "mul2_result");
        apb_xfer(0, 8'h08, 0, "mul2_ctrl");

        // Invalid command with interrupt enabled
        apb_xfer(1, 8'h08, 32'h30C, "inv_start");
        idle(2);
        check("inv_irq_held", 32'(bus.irq), 32'h1);
        apb_xfer(0, 8'h10, 0, "inv_status");
        apb_xfer(0, 8'h0C, 0, "inv_result");

        // CMP equal, then write to unmapped
        apb_xfer(1, 8'h00, 32'h05, "cmp_opa");
        apb_xfer(1, 8'h04, 32'h05, "cmp_opb");
        apb_xfer(1, 8'h08, 32'h109, "cmp_start");
        apb_xfer(0, 8'h10, 0, "cmp_status");
        apb_xfer(0, 8'h0C, 0, "cmp_result");
        apb_xfer(1, 8'h14, 32'h1234, "unmapped_wr");
        apb_xfer(0, 8'h14, 0, "unmapped_rd");

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            int kind = $urandom_range(0, 5);
            logic [31:0] d = $urandom;
            case (kind)
                0: apb_xfer(1, 8'h00, d, "rnd_opa");
                1: apb_xfer(1, 8'h04, d, "rnd_opb");
                2: begin
                    int c = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                    logic [31:0] w = 32'(c);
                    if ($urandom_range(0, 3) != 0) w = w | 32'h100;
                    if ($urandom_range(0, 1) == 1) w = w | 32'h200;
                    apb_xfer(1, 8'h08, w, "rnd_ctrl");
                end
                3: apb_xfer(0, addrs[$urandom_range(0, 8)], 0, "rnd_read");
                4: apb_xfer(1, addrs[$urandom_range(0, 8)], d, "rnd_write");
                default: idle($urandom_range(0, 3));
            endcase
        end

        // Reset during the second EXEC cycle of a MUL
        apb_xfer(1, 8'h00, 32'h0F, "rmul_opa");
        apb_xfer(1, 8'h04, 32'h0F, "rmul_opb");
        apb_xfer(1, 8'h08, 32'h108, "rmul_start");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(3);
        check("midop_irq", 32'(bus.irq), 32'h0);
        apb_xfer(0, 8'h10, 0, "midop_status");
        apb_xfer(0, 8'h0C, 0, "midop_result");
        apb_xfer(0, 8'h00, 0, "midop_opa");

        idle(2);
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d responses never observed", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
